// File: rtl/qracc_pkg.sv
// Shared types and defaults for the QR accelerator datapath blocks.
package qracc_pkg;

  localparam int QRACC_PSUM_WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    PSUM_IDLE  = 2'd0,
    PSUM_ACCUM = 2'd1,
    PSUM_HOLD  = 2'd2
  } qracc_psum_state_t;

endpackage

// File: rtl/psum_sat_add.sv
// One element of the partial-sum datapath: sign-extend, load or add, and
// clamp when QRACC_PSUM_SATURATE_EN is defined (otherwise wrap, no overflow).
module psum_sat_add
  import qracc_pkg::*;
#(
  parameter int inputWidth = 16,
  parameter int psumWidth  = QRACC_PSUM_WIDTH_DEFAULT
) (
  input  logic                  load_i,
  input  logic [inputWidth-1:0] in_i,
  input  logic [psumWidth-1:0]  acc_i,
  output logic [psumWidth-1:0]  sum_o,
  output logic                  ovf_o
);

  logic [psumWidth-1:0] ext_s;

  assign ext_s = psumWidth'($signed(in_i));

`ifdef QRACC_PSUM_SATURATE_EN
  // One guard bit: overflow exactly when the top two bits of the sum disagree.
  logic [psumWidth:0] wide_s;

  always_comb begin
    wide_s = {acc_i[psumWidth-1], acc_i} + {ext_s[psumWidth-1], ext_s};
    sum_o  = wide_s[psumWidth-1:0];
    ovf_o  = 1'b0;
    if (load_i) begin
      sum_o = ext_s;
    end else if (wide_s[psumWidth] != wide_s[psumWidth-1]) begin
      ovf_o = 1'b1;
      sum_o = wide_s[psumWidth] ? {1'b1, {(psumWidth-1){1'b0}}}
                                : {1'b0, {(psumWidth-1){1'b1}}};
    end else begin
      sum_o = wide_s[psumWidth-1:0];
    end
  end
`else
  always_comb begin
    ovf_o = 1'b0;
    if (load_i) begin
      sum_o = ext_s;
    end else begin
      sum_o = acc_i + ext_s;
    end
  end
`endif

endmodule

// File: rtl/qracc_psum_accumulator.sv
// Sums K seq_acc tiles per output group for G groups, handing each sum off via
// valid/ready. Saturating adds are selected with QRACC_PSUM_SATURATE_EN.
module qracc_psum_accumulator
  import qracc_pkg::*;
#(
  parameter int numElements   = 32,
  parameter int inputWidth    = 16,
  parameter int psumWidth     = QRACC_PSUM_WIDTH_DEFAULT,
  parameter int tileCntWidth  = 8,
  parameter int groupCntWidth = 16
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             start_i,
  input  logic [tileCntWidth-1:0]          num_tiles_i,
  input  logic [groupCntWidth-1:0]         num_groups_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [numElements*inputWidth-1:0] in_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [numElements*psumWidth-1:0] out_data_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overflow_o
);

  qracc_psum_state_t state_q, state_d;

  logic [tileCntWidth-1:0]  tile_cnt_q, tile_cnt_d, num_tiles_q, num_tiles_d;
  logic [groupCntWidth-1:0] group_cnt_q, group_cnt_d, num_groups_q, num_groups_d;
  logic [numElements-1:0][psumWidth-1:0] acc_q, acc_d, sum_s;
  logic [numElements-1:0] elem_ovf_s;
  logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic start_s, beat_s, hs_s, last_tile_s, last_group_s, load_s;

  assign start_s      = (state_q == PSUM_IDLE) && start_i;
  assign beat_s       = (state_q == PSUM_ACCUM) && in_valid_i;
  assign hs_s         = (state_q == PSUM_HOLD) && out_ready_i;
  assign last_tile_s  = (tile_cnt_q + tileCntWidth'(1)) == num_tiles_q;
  assign last_group_s = (group_cnt_q + groupCntWidth'(1)) == num_groups_q;
  // The first tile of a group overwrites the accumulator, so no clear cycle is needed.
  assign load_s       = (tile_cnt_q == {tileCntWidth{1'b0}});

  for (genvar e = 0; e < numElements; e++) begin : g_elem
    psum_sat_add #(
      .inputWidth(inputWidth),
      .psumWidth (psumWidth)
    ) u_add (
      .load_i(load_s),
      .in_i  (in_data_i[e*inputWidth +: inputWidth]),
      .acc_i (acc_q[e]),
      .sum_o (sum_s[e]),
      .ovf_o (elem_ovf_s[e])
    );
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= PSUM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PSUM_IDLE:  state_d = start_i ? PSUM_ACCUM : PSUM_IDLE;
      PSUM_ACCUM: state_d = (in_valid_i && last_tile_s) ? PSUM_HOLD : PSUM_ACCUM;
      PSUM_HOLD: begin
        if (out_ready_i) begin
          state_d = last_group_s ? PSUM_IDLE : PSUM_ACCUM;
        end else begin
          state_d = PSUM_HOLD;
        end
      end
      default:    state_d = PSUM_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      PSUM_ACCUM: in_ready_o  = 1'b1;
      PSUM_HOLD:  out_valid_o = 1'b1;
      default: begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    num_tiles_d  = num_tiles_q;
    num_groups_d = num_groups_q;
    tile_cnt_d   = tile_cnt_q;
    group_cnt_d  = group_cnt_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    busy_d       = busy_q;
    done_d       = hs_s && last_group_s;
    if (start_s) begin
      // A zero count means one, so the compare against the counter never misses.
      num_tiles_d  = (num_tiles_i == {tileCntWidth{1'b0}}) ? tileCntWidth'(1) : num_tiles_i;
      num_groups_d = (num_groups_i == {groupCntWidth{1'b0}}) ? groupCntWidth'(1) : num_groups_i;
      tile_cnt_d   = {tileCntWidth{1'b0}};
      group_cnt_d  = {groupCntWidth{1'b0}};
      ovf_d        = 1'b0;
      busy_d       = 1'b1;
    end else if (beat_s) begin
      acc_d      = sum_s;
      ovf_d      = ovf_q | (|elem_ovf_s);
      tile_cnt_d = last_tile_s ? {tileCntWidth{1'b0}} : tile_cnt_q + tileCntWidth'(1);
    end else if (hs_s) begin
      group_cnt_d = group_cnt_q + groupCntWidth'(1);
      busy_d      = last_group_s ? 1'b0 : busy_q;
    end else begin
      busy_d = busy_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      num_tiles_q  <= {tileCntWidth{1'b0}};
      num_groups_q <= {groupCntWidth{1'b0}};
      tile_cnt_q   <= {tileCntWidth{1'b0}};
      group_cnt_q  <= {groupCntWidth{1'b0}};
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      num_tiles_q  <= num_tiles_d;
      num_groups_q <= num_groups_d;
      tile_cnt_q   <= tile_cnt_d;
      group_cnt_q  <= group_cnt_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out_data_o = acc_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule
